// File: rtl/berzerk_input_ctrl.sv
// Berzerk input conditioning: PS/2 + joystick merge into player controls, and a
// rate-limited coin pulse generator. Optional macro SOCD_CLEAN_EN cancels opposing directions.
module berzerk_input_ctrl #(
  parameter int COIN_PULSE_CYC = 4000000,
  parameter int COIN_GAP_CYC   = 4000000,
  parameter int CNT_W          = 23
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  output logic [4:0]  p1_ctrl,
  output logic [4:0]  p2_ctrl,
  output logic        start1,
  output logic        start2,
  output logic        coin,
  output logic        coin_busy
);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} coin_state_t;

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(COIN_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(COIN_GAP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic toggle_q;
  logic up1, down1, left1, right1, space1, ctrl1;
  logic f1, one_key, f2, two_key, coin_a, coin_b;
  logic up2, down2, left2, right2, fire2;

  coin_state_t     state;
  logic [CNT_W-1:0] cnt;
  logic            pending, req_q;

  logic key_event, pressed, coin_req, coin_edge;
  logic [4:0] keyset1, keyset2;

  // Joystick bits above coin are not part of this block's control set.
  logic unused_joy_hi;
  assign unused_joy_hi = ^{joystick_0[15:8], joystick_1[15:8]};

  assign key_event = ps2_key[10] ^ toggle_q;
  assign pressed   = ps2_key[9];
  assign keyset1   = {space1 | ctrl1, up1, down1, left1, right1};
  assign keyset2   = {fire2, up2, down2, left2, right2};
  assign coin_req  = coin_a | coin_b | joystick_0[7] | joystick_1[7];
  assign coin_edge = coin_req & ~req_q;

  function automatic logic [4:0] socd_clean(input logic [4:0] v);
    socd_clean = v;
`ifdef SOCD_CLEAN_EN
    if (v[3] && v[2]) socd_clean[3:2] = 2'b00;
    if (v[1] && v[0]) socd_clean[1:0] = 2'b00;
`endif
  endfunction

  // NOTE: every state register below uses <= so all updates see pre-edge values.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      toggle_q <= 1'b0;
      {up1, down1, left1, right1, space1, ctrl1} <= '0;
      {f1, one_key, f2, two_key, coin_a, coin_b} <= '0;
      {up2, down2, left2, right2, fire2}         <= '0;
      p1_ctrl <= '0;
      p2_ctrl <= '0;
      start1  <= 1'b0;
      start2  <= 1'b0;
    end else begin
      toggle_q <= ps2_key[10];
      if (key_event) begin
        // Arrows are matched on the scancode alone, with or without the E0 prefix.
        case (ps2_key[7:0])
          8'h75:   up1    <= pressed;
          8'h72:   down1  <= pressed;
          8'h6B:   left1  <= pressed;
          8'h74:   right1 <= pressed;
          default: ;
        endcase
        case (ps2_key[8:0])
          9'h029:  space1  <= pressed;
          9'h014:  ctrl1   <= pressed;
          9'h005:  f1      <= pressed;
          9'h016:  one_key <= pressed;
          9'h006:  f2      <= pressed;
          9'h01E:  two_key <= pressed;
          9'h02E:  coin_a  <= pressed;
          9'h036:  coin_b  <= pressed;
          9'h02D:  up2     <= pressed;
          9'h02B:  down2   <= pressed;
          9'h023:  left2   <= pressed;
          9'h034:  right2  <= pressed;
          9'h01C:  fire2   <= pressed;
          default: ;
        endcase
      end
      p1_ctrl <= socd_clean(keyset1 | joystick_0[4:0]);
      p2_ctrl <= socd_clean(keyset2 | joystick_1[4:0]);
      start1  <= f1 | one_key | joystick_0[5] | joystick_1[5];
      start2  <= f2 | two_key | joystick_0[6] | joystick_1[6];
    end
  end

  // Coin FSM: one fixed-width pulse per request edge, at most one request queued.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      pending   <= 1'b0;
      req_q     <= 1'b0;
      coin      <= 1'b0;
      coin_busy <= 1'b0;
    end else begin
      req_q <= coin_req;
      unique case (state)
        IDLE: begin
          if (coin_edge || pending) begin
            state     <= PULSE;
            cnt       <= PULSE_LOAD;
            coin      <= 1'b1;
            coin_busy <= 1'b1;
            pending   <= 1'b0;
          end
        end
        PULSE: begin
          if (coin_edge) pending <= 1'b1;
          if (cnt == '0) begin
            state <= GAP;
            cnt   <= GAP_LOAD;
            coin  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        GAP: begin
          if (coin_edge) pending <= 1'b1;
          if (cnt == '0) begin
            state     <= IDLE;
            coin_busy <= 1'b0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: begin
          state     <= IDLE;
          coin      <= 1'b0;
          coin_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_berzerk_input_ctrl.sv
// Self-checking bench for berzerk_input_ctrl: directed steps plus random traffic
// against a key-bitmap and coin-timeline reference model.
module tb_berzerk_input_ctrl;

  localparam int P = 4;
  localparam int G = 3;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic [15:0] joystick_0, joystick_1;
  logic [4:0]  p1_ctrl, p2_ctrl;
  logic        start1, start2, coin, coin_busy;

  berzerk_input_ctrl #(.COIN_PULSE_CYC(P), .COIN_GAP_CYC(G), .CNT_W(4)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key),
    .joystick_0(joystick_0), .joystick_1(joystick_1),
    .p1_ctrl(p1_ctrl), .p2_ctrl(p2_ctrl), .start1(start1), .start2(start2),
    .coin(coin), .coin_busy(coin_busy)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  // Reference model: pressed state per 9-bit code, arrow state per 8-bit code,
  // and coin pulses as a timeline of start cycles.
  bit kp [512];
  bit arr [256];
  bit tog_prev, req_prev, pending;
  int last_start, k;
  logic [4:0] e_p1, e_p2;
  logic e_s1, e_s2;
  logic prev_coin;
  int coin_hi, busy_hi, rises;
  int starts[$];

  logic [8:0] key_list [22] = '{9'h075, 9'h175, 9'h072, 9'h172, 9'h06B, 9'h16B, 9'h074, 9'h174,
                                9'h029, 9'h014, 9'h005, 9'h016, 9'h006, 9'h01E, 9'h02E, 9'h036,
                                9'h02D, 9'h02B, 9'h023, 9'h034, 9'h01C, 9'h129};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] clean(input logic [4:0] v);
    clean = v;
`ifdef SOCD_CLEAN_EN
    if (v[3] && v[2]) clean[3:2] = 2'b00;
    if (v[1] && v[0]) clean[1:0] = 2'b00;
`endif
  endfunction

  task automatic model_reset();
    foreach (kp[i]) kp[i] = 1'b0;
    foreach (arr[i]) arr[i] = 1'b0;
    tog_prev   = 1'b0;
    req_prev   = 1'b0;
    pending    = 1'b0;
    last_start = -1000;
  endtask

  // One clock: predict from pre-edge state and inputs, advance the model, compare.
  task automatic cycle();
    logic req, edg, idle;
    e_p1 = clean({kp[9'h029] | kp[9'h014], arr[8'h75], arr[8'h72], arr[8'h6B], arr[8'h74]}
                 | joystick_0[4:0]);
    e_p2 = clean({kp[9'h01C], kp[9'h02D], kp[9'h02B], kp[9'h023], kp[9'h034]} | joystick_1[4:0]);
    e_s1 = kp[9'h005] | kp[9'h016] | joystick_0[5] | joystick_1[5];
    e_s2 = kp[9'h006] | kp[9'h01E] | joystick_0[6] | joystick_1[6];
    req  = kp[9'h02E] | kp[9'h036] | joystick_0[7] | joystick_1[7];
    edg  = req & ~req_prev;
    req_prev = req;
    idle = (k >= last_start + P + G + 1);
    if (idle && (edg || pending)) begin
      last_start = k;
      pending    = 1'b0;
    end else if (edg) begin
      pending = 1'b1;
    end
    if (ps2_key[10] != tog_prev) begin
      kp[ps2_key[8:0]]  = ps2_key[9];
      arr[ps2_key[7:0]] = ps2_key[9];
    end
    tog_prev = ps2_key[10];
    @(posedge clk_sys);
    #1;
    check("p1_ctrl", 32'(p1_ctrl), 32'(e_p1));
    check("p2_ctrl", 32'(p2_ctrl), 32'(e_p2));
    check("start1", 32'(start1), 32'(e_s1));
    check("start2", 32'(start2), 32'(e_s2));
    check("coin", 32'(coin), 32'(k - last_start < P));
    check("coin_busy", 32'(coin_busy), 32'(k - last_start < P + G));
    k++;
  endtask

  task automatic key(input logic pr, input logic [8:0] code);
    ps2_key = {~ps2_key[10], pr, code};
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    check("rst_coin", 32'(coin), 32'd0);
    check("rst_busy", 32'(coin_busy), 32'd0);
    ps2_key    = '0;
    joystick_0 = '0;
    joystick_1 = '0;
    model_reset();
    repeat (2) @(posedge clk_sys);
    #2;
    check("rst_p1", 32'(p1_ctrl), 32'd0);
    check("rst_coin_hold", 32'(coin), 32'd0);
    reset_n = 1'b1;
  endtask

  initial begin
    k          = 0;
    ps2_key    = '0;
    joystick_0 = '0;
    joystick_1 = '0;
    apply_reset();

    // Idle after reset.
    repeat (100) cycle();

    // Extended up arrow press, then release without E0.
    key(1'b1, 9'h175);
    cycle();
    check("kb_lat1", 32'(p1_ctrl), 32'd0);
    cycle();
    check("kb_up", 32'(p1_ctrl), 32'b01000);
    key(1'b0, 9'h075);
    repeat (2) cycle();
    check("kb_up_rel", 32'(p1_ctrl), 32'd0);

    // Start 2 from key "2", then from joystick_1[6].
    key(1'b1, 9'h01E);
    repeat (2) cycle();
    check("st2_key", 32'(start2), 32'd1);
    check("st1_quiet", 32'(start1), 32'd0);
    key(1'b0, 9'h01E);
    repeat (2) cycle();
    joystick_1[6] = 1'b1;
    cycle();
    check("st2_joy", 32'(start2), 32'd1);
    joystick_1 = '0;
    repeat (2) cycle();

    // Opposing directions on the joystick.
    joystick_0 = 16'h000C;
    cycle();
`ifdef SOCD_CLEAN_EN
    check("socd", 32'(p1_ctrl), 32'd0);
`else
    check("socd", 32'(p1_ctrl), 32'b01100);
`endif
    joystick_0 = '0;
    repeat (2) cycle();

    // Held coin request gives a single pulse.
    coin_hi = 0; busy_hi = 0; rises = 0; prev_coin = 1'b0;
    joystick_0[7] = 1'b1;
    repeat (50) begin
      cycle();
      coin_hi += int'(coin);
      busy_hi += int'(coin_busy);
      if (coin && !prev_coin) rises++;
      prev_coin = coin;
    end
    joystick_0[7] = 1'b0;
    repeat (10) cycle();
    check("coin_width", 32'(coin_hi), 32'(P));
    check("coin_once", 32'(rises), 32'd1);
    check("busy_width", 32'(busy_hi), 32'(P + G));

    // Three edges inside the pulse: one queued, one dropped.
    prev_coin = 1'b0;
    for (int i = 0; i < 40; i++) begin
      joystick_0[7] = (i < 6) && (i % 2 == 0);
      cycle();
      if (coin && !prev_coin) starts.push_back(k);
      prev_coin = coin;
    end
    check("queue_count", 32'(starts.size()), 32'd2);
    if (starts.size() == 2) check("queue_spacing", 32'(starts[1] - starts[0]), 32'(P + G + 1));

    // Reset in the middle of a pulse with a request pending.
    joystick_0[7] = 1'b1; cycle();
    joystick_0[7] = 1'b0; cycle();
    joystick_0[7] = 1'b1; cycle();
    joystick_0[7] = 1'b0;
    check("pre_rst_coin", 32'(coin), 32'd1);
    apply_reset();
    rises = 0;
    repeat (30) begin
      cycle();
      rises += int'(coin);
    end
    check("no_pulse_after_rst", 32'(rises), 32'd0);

    // Random keyboard and joystick traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) begin
        if ($urandom_range(7) == 0) key(1'($urandom), 9'($urandom));
        else key(1'($urandom), key_list[$urandom_range(21)]);
      end
      if ($urandom_range(7) == 0) begin
        joystick_0 = 16'($urandom);
        joystick_1 = 16'($urandom);
        joystick_0[7] = ($urandom_range(7) == 0);
        joystick_1[7] = ($urandom_range(7) == 0);
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
